// File: rtl/uart_tx_engine.sv
// uart_tx_engine: RS232 transmitter engine. It sends DATA_BITS data bits LSB first.
// Each frame has one start bit, an optional parity bit and STOP_BITS stop bits.
// A one-entry holding register with a valid/ready handshake lets frames run back to back.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the data bits.
// parity_odd selects the sense: 1 is odd, 0 is even.
module uart_tx_engine #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned CLK_DIV   = 434,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic                 parity_odd,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done,
   output logic [2:0]           tx_state
);

   localparam int unsigned BaudW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CntW  = $clog2(DATA_BITS + 1);

   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLK_DIV - 1);
   localparam logic [CntW-1:0]  DataLast = CntW'(DATA_BITS - 1);
   localparam logic [CntW-1:0]  StopLast = CntW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      StIdle   = 3'b000,
      StStart  = 3'b001,
      StData   = 3'b010,
      StParity = 3'b011,
      StStop   = 3'b100
   } state_e;

   state_e               state_q, state_d;
   logic [BaudW-1:0]     baud_q, baud_d;
   logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 hold_full_q, hold_full_d;
   logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
   logic                 tx_q, tx_d;
   logic                 accept;
   logic                 load;
   logic                 bit_end;

`ifdef UART_TX_PARITY_EN
   logic                 hold_odd_q, hold_odd_d;
   logic                 par_q, par_d;
`else
   logic                 unused_parity_odd;
   assign unused_parity_odd = parity_odd;
`endif

   assign accept   = tx_valid & ~hold_full_q;
   assign bit_end  = (baud_q == BaudLast);
   assign tx_ready = ~hold_full_q;
   assign busy     = (state_q != StIdle);
   assign tx_state = state_q;
   assign tx       = tx_q;

   // Holding register: filled on accept, emptied when the engine loads the word.
   always_comb begin
      hold_full_d = hold_full_q;
      hold_data_d = hold_data_q;
      if (load) begin
         hold_full_d = 1'b0;
      end
      // accept and load are exclusive: accept needs an empty hold, load a full one
      if (accept) begin
         hold_full_d = 1'b1;
         hold_data_d = tx_data;
      end
   end

`ifdef UART_TX_PARITY_EN
   // The parity sense travels with the word; parity is fixed at load time.
   always_comb begin
      hold_odd_d = accept ? parity_odd : hold_odd_q;
      par_d      = load ? ((^hold_data_q) ^ hold_odd_q) : par_q;
   end
`endif

   // Frame sequencing: next state, baud divider, bit counter, shift register.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q + BaudW'(1);
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      load      = 1'b0;
      tx_done   = 1'b0;

      case (state_q)
         StIdle: begin
            baud_d    = '0;
            bit_cnt_d = '0;
            if (hold_full_q) begin
               load    = 1'b1;
               shift_d = hold_data_q;
               state_d = StStart;
            end
         end

         StStart: begin
            if (bit_end) begin
               baud_d    = '0;
               bit_cnt_d = '0;
               state_d   = StData;
            end
         end

         StData: begin
            if (bit_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_cnt_q == DataLast) begin
                  bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = StParity;
`else
                  state_d   = StStop;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + CntW'(1);
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bit_end) begin
               baud_d    = '0;
               bit_cnt_d = '0;
               state_d   = StStop;
            end
         end
`endif

         StStop: begin
            // bit_cnt_q counts stop bits here
            if (bit_end) begin
               baud_d = '0;
               if (bit_cnt_q == StopLast) begin
                  tx_done   = 1'b1;
                  bit_cnt_d = '0;
                  if (hold_full_q) begin
                     load    = 1'b1;
                     shift_d = hold_data_q;
                     state_d = StStart;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CntW'(1);
               end
            end
         end

         default: begin
            baud_d    = '0;
            bit_cnt_d = '0;
            state_d   = StIdle;
         end
      endcase
   end

   // Line level for the next cycle, derived from next state so that tx leaves a flop.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = par_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   // State and datapath registers; reset drives the line idle immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         baud_q      <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         hold_full_q <= 1'b0;
         hold_data_q <= '0;
         tx_q        <= 1'b1;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         hold_full_q <= hold_full_d;
         hold_data_q <= hold_data_d;
         tx_q        <= tx_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   // Parity sense and computed parity bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_odd_q <= 1'b0;
         par_q      <= 1'b0;
      end else begin
         hold_odd_q <= hold_odd_d;
         par_q      <= par_d;
      end
   end
`endif

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Parametrised RS232 transmitter engine for the peripheral bus UART: one block holds the control FSM, the baud-tick divider, the bit counter and the shift register. It serialises a word of DATA_BITS bits, LSB first, framed by one start bit, an optional parity bit and 1 or 2 stop bits. A one-entry holding register with a valid/ready handshake allows back-to-back frames with no idle gap. It sits between the UART register interface (write side) and the serial TX pin.

## Interface
- DATA_BITS, 8, payload width; legal 5..9
- CLK_DIV, 434, clk cycles per bit time; legal >= 2
- STOP_BITS, 1, stop bits per frame; legal 1 or 2
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- tx_data  input  DATA_BITS  word to send, sampled on accept
- tx_valid  input  1  writer has a word on tx_data
- tx_ready  output  1  holding register empty; accept = tx_valid & tx_ready at a clk edge
- parity_odd  input  1  parity sense (1 odd, 0 even), sampled on accept; used only with UART_TX_PARITY_EN
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress (state != IDLE)
- tx_done  output  1  one-cycle pulse on last cycle of final stop bit
- tx_state  output  3  current FSM state code, for debug

## Operation
- States (codes): IDLE 000, START 001, DATA 010, PARITY 011, STOP 100; other codes -> IDLE next cycle.
- Holding register: set on accept, cleared when engine loads it; tx_ready = !hold_full (registered).
- IDLE: tx=1; if hold_full -> load shift register and parity-sense from hold, clear hold, go START.
- START: tx=0 for CLK_DIV cycles, then DATA with bit counter = 0.
- DATA: tx = shift[0]; on each bit-time end shift right, counter+1; after DATA_BITS bits -> PARITY if UART_TX_PARITY_EN else STOP.
- PARITY: tx = XOR of loaded word XOR parity_odd, CLK_DIV cycles, then STOP.
- STOP: tx=1 for STOP_BITS*CLK_DIV cycles; on last cycle tx_done=1; then if hold_full load and go START directly (no idle cycle), else IDLE.
- Baud divider: counts 0..CLK_DIV-1, cleared on every state entry; bit-time end when count = CLK_DIV-1. Width $clog2(CLK_DIV).
- Bit counter width $clog2(DATA_BITS+1); never exceeds DATA_BITS.
- New accepts allowed during any state while hold empty; tx_data changes after accept do not affect the frame.

## Timing
- Reset values: tx=1, tx_ready=1, busy=0, tx_done=0, tx_state=000; hold, shift, counters cleared.
- Reset asserted mid-frame: tx returns to 1 immediately (async), pending hold word discarded.
- Accept at edge N with engine IDLE: hold_full after N, START entered and tx=0 after N+1.
- Frame length F = (1 + DATA_BITS + P + STOP_BITS)*CLK_DIV cycles, P = 1 with parity else 0; tx_done asserted in cycle F of the frame counted from START entry.
- Back-to-back: next START begins the cycle after tx_done; tx_ready rises the cycle after each load.
- tx_valid with tx_ready=0: ignored, writer must hold tx_valid until accept.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state present, parity_odd used, P=1.
- Undefined: PARITY state never entered (code 011 treated as illegal -> IDLE), parity_odd ignored, P=0, DATA goes straight to STOP.

## Test plan
- Reset: hold rst=0 for 3 cycles -> tx=1, tx_ready=1, busy=0, tx_state=000; release, no activity with tx_valid=0.
- Single frame, DATA_BITS=8, CLK_DIV=4, no parity, 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1 each held 4 cycles, tx_done at cycle 40, then IDLE.
- Parity (macro defined), 0xA5 with parity_odd=0 -> parity bit 0; parity_odd=1 -> 1; frame 44 cycles.
- Back-to-back: accept 0x55 then 0x0F during first frame -> tx_ready low until load, second start bit the cycle after first tx_done, no idle high gap.
- STOP_BITS=2, CLK_DIV=4 -> stop high 8 cycles, tx_done on 8th.
- Mid-frame reset during DATA bit 3 with hold full -> tx=1 immediately, tx_ready=1, next frame starts clean after release.
